// File: rtl/zbb_bitcnt.sv
// Multi-cycle Zbb bit-count unit: decodes CLZ/CTZ/CPOP and scans the latched
// operand BITS_PER_CYCLE bits per cycle, stalling the core until the result is ready.
module zbb_bitcnt #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] din_rs1,
    input  logic [6:0]  cmdOp,
    input  logic [2:0]  cmdF3,
    input  logic [6:0]  cmdF7,
    input  logic [4:0]  cmdRs2,
    output logic        isBitcnt,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] dout_rd
);
    localparam int         N         = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] LAST_BEAT = 6'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_CLZ = 2'd0, OP_CTZ = 2'd1, OP_CPOP = 2'd2} op_t;

    state_t                    state, state_next;
    op_t                       op;
    logic [31:0]               opnd, opnd_next;
    logic [5:0]                cnt, cnt_next, add, beat;
    logic                      found, found_next;
    logic                      accept, last;
    logic [BITS_PER_CYCLE-1:0] grp;

    assign isBitcnt = (cmdOp == 7'b0010011) && (cmdF3 == 3'b001) &&
                      (cmdF7 == 7'b0110000) && (cmdRs2 <= 5'd2);
    assign accept   = (state == IDLE) && start && isBitcnt;
    assign stall    = accept || (state == RUN);
    assign last     = (beat == LAST_BEAT);

    // NOTE: assign a default before the case so no path leaves state_next unassigned (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last)   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Group bits are arranged in scan order so CLZ and CTZ share one counting loop.
    // NOTE: blocking assignments here are intentional; each loop pass builds on the previous one.
    always_comb begin
        grp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            grp[i] = (op == OP_CLZ) ? opnd[31 - i] : opnd[i];
        end
        add        = '0;
        found_next = found;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (op == OP_CPOP) begin
                add = add + {5'd0, grp[i]};
            end else if (!found_next) begin
                if (grp[i]) found_next = 1'b1;
                else        add = add + 6'd1;
            end
        end
        cnt_next  = cnt + add;
        opnd_next = (op == OP_CLZ) ? (opnd << BITS_PER_CYCLE) : (opnd >> BITS_PER_CYCLE);
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op      <= OP_CLZ;
            opnd    <= '0;
            cnt     <= '0;
            found   <= 1'b0;
            beat    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dout_rd <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state_next == DONE);
            if (accept) begin
                op    <= op_t'(cmdRs2[1:0]);
                opnd  <= din_rs1;
                cnt   <= '0;
                found <= 1'b0;
                beat  <= '0;
            end else if (state == RUN) begin
                opnd  <= opnd_next;
                cnt   <= cnt_next;
                found <= found_next;
                beat  <= beat + 6'd1;
                if (last) dout_rd <= {26'd0, cnt_next};
            end
        end
    end
endmodule

// File: tb/tb_zbb_bitcnt.sv
// Self-checking bench for zbb_bitcnt: three instances (1, 4 and 8 bits per cycle)
// share clock, reset and operand/command inputs; each has its own start.
module tb_zbb_bitcnt;
    logic        clk;
    logic        rst_n;
    logic        start_v [3];
    logic [31:0] din_rs1;
    logic [6:0]  cmdOp;
    logic [2:0]  cmdF3;
    logic [6:0]  cmdF7;
    logic [4:0]  cmdRs2;
    logic        isb_v   [3];
    logic        stall_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic [31:0] dout_v  [3];
    logic [31:0] last_dout [3];

    int errors = 0;
    int checks = 0;

    zbb_bitcnt #(.BITS_PER_CYCLE(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .din_rs1(din_rs1),
        .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7), .cmdRs2(cmdRs2),
        .isBitcnt(isb_v[0]), .stall(stall_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .dout_rd(dout_v[0]));

    zbb_bitcnt #(.BITS_PER_CYCLE(4)) u_b4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .din_rs1(din_rs1),
        .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7), .cmdRs2(cmdRs2),
        .isBitcnt(isb_v[1]), .stall(stall_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .dout_rd(dout_v[1]));

    zbb_bitcnt #(.BITS_PER_CYCLE(8)) u_b8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .din_rs1(din_rs1),
        .cmdOp(cmdOp), .cmdF3(cmdF3), .cmdF7(cmdF7), .cmdRs2(cmdRs2),
        .isBitcnt(isb_v[2]), .stall(stall_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .dout_rd(dout_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] v;
        logic [4:0]  rs2;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bits_per_cycle(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 8;
        endcase
    endfunction

    // Reference: count straight from the definitions over the whole word.
    function automatic logic [31:0] ref_count(input logic [31:0] v, input logic [4:0] rs2);
        int n;
        n = 0;
        case (rs2)
            5'd0:    begin int i; i = 31; while (i >= 0 && !v[i]) begin n++; i--; end end
            5'd1:    begin int i; i = 0;  while (i <= 31 && !v[i]) begin n++; i++; end end
            default: n = $countones(v);
        endcase
        return 32'(n);
    endfunction

    task automatic set_cmd(input logic [4:0] rs2);
        cmdOp  = 7'b0010011;
        cmdF3  = 3'b001;
        cmdF7  = 7'b0110000;
        cmdRs2 = rs2;
    endtask

    // Called just after a falling edge; that clock cycle is cycle 0 of the instruction.
    task automatic run_op(input int k, input logic [31:0] v, input logic [4:0] rs2,
                          input logic [31:0] exp, input string name, input bit hold);
        int got;
        bit stall_ok;
        din_rs1    = v;
        set_cmd(rs2);
        start_v[k] = 1'b1;
        #1;
        check({name, " isBitcnt"}, 32'(isb_v[k]), 32'd1);
        check({name, " stall cycle0"}, 32'(stall_v[k]), 32'd1);
        got      = -1;
        stall_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!hold) begin
                start_v[k] = 1'b0;
                din_rs1    = $urandom;
                cmdRs2     = 5'($urandom);
            end
            #1;
            if (done_v[k]) begin
                got = c;
                break;
            end
            if (!stall_v[k] || !busy_v[k]) stall_ok = 1'b0;
        end
        check({name, " done cycle"}, 32'(got), 32'(32 / bits_per_cycle(k) + 1));
        check({name, " stall/busy in run"}, 32'(stall_ok), 32'd1);
        check({name, " stall in done"}, 32'(stall_v[k]), 32'd0);
        check({name, " result"}, dout_v[k], exp);
        last_dout[k] = exp;
        if (!hold) begin
            @(negedge clk);
            #1;
            check({name, " done single pulse"}, 32'(done_v[k]), 32'd0);
            check({name, " idle after done"}, 32'(busy_v[k]), 32'd0);
        end
    endtask

    initial begin
        bit seen;
        logic [31:0] v;
        logic [4:0]  rs2;
        int          k;

        vecs[0] = '{32'hF0F0_0001, 5'd2, 32'd9};
        vecs[1] = '{32'h0000_0000, 5'd0, 32'd32};
        vecs[2] = '{32'h0001_0000, 5'd0, 32'd15};
        vecs[3] = '{32'h8000_0000, 5'd1, 32'd31};
        vecs[4] = '{32'h0000_0001, 5'd1, 32'd0};

        for (int i = 0; i < 3; i++) begin
            start_v[i]   = 1'b0;
            last_dout[i] = '0;
        end
        din_rs1 = '0;
        set_cmd(5'd2);
        rst_n = 1'b1;
        #2;
        rst_n      = 1'b0;
        start_v[1] = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset busy k%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("reset done k%0d", i), 32'(done_v[i]), 32'd0);
            check($sformatf("reset dout k%0d", i), dout_v[i], 32'd0);
        end
        check("reset stall with start", 32'(stall_v[1]), 32'd1);
        check("reset stall without start", 32'(stall_v[0]), 32'd0);
        @(negedge clk);
        @(negedge clk);
        start_v[1] = 1'b0;
        rst_n      = 1'b1;
        #1;

        for (int k2 = 0; k2 < 3; k2++) begin
            for (int i = 0; i < 5; i++) begin
                run_op(k2, vecs[i].v, vecs[i].rs2, vecs[i].exp,
                       $sformatf("vec%0d k%0d", i, k2), 1'b0);
            end
        end

        // Non-matching decodes leave the unit idle and the result untouched.
        run_op(1, 32'h0000_00FF, 5'd2, 32'd8, "cpop ff", 1'b0);
        din_rs1    = $urandom;
        set_cmd(5'd3);
        start_v[1] = 1'b1;
        #1;
        check("rs2=3 isBitcnt", 32'(isb_v[1]), 32'd0);
        check("rs2=3 stall", 32'(stall_v[1]), 32'd0);
        @(negedge clk);
        set_cmd(5'd0);
        cmdF7 = 7'b0100000;
        #1;
        check("rs2=3 busy", 32'(busy_v[1]), 32'd0);
        check("rs2=3 dout", dout_v[1], last_dout[1]);
        check("bad f7 isBitcnt", 32'(isb_v[1]), 32'd0);
        check("bad f7 stall", 32'(stall_v[1]), 32'd0);
        @(negedge clk);
        start_v[1] = 1'b0;
        #1;
        check("bad f7 busy", 32'(busy_v[1]), 32'd0);
        check("bad f7 dout", dout_v[1], last_dout[1]);

        // Reset dropped in RUN cycle 3 aborts the operation without a done.
        din_rs1    = 32'hFFFF_FFFF;
        set_cmd(5'd2);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midrun busy before reset", 32'(busy_v[1]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrun reset busy", 32'(busy_v[1]), 32'd0);
        check("midrun reset done", 32'(done_v[1]), 32'd0);
        check("midrun reset dout", dout_v[1], 32'd0);
        check("midrun reset stall", 32'(stall_v[1]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done_v[1] || busy_v[1]) seen = 1'b1;
        end
        check("no done after aborted op", 32'(seen), 32'd0);
        last_dout[1] = '0;

        // Instruction held through DONE, then a back-to-back CTZ in the next IDLE cycle.
        run_op(1, 32'h0001_0000, 5'd0, 32'd15, "held clz", 1'b1);
        @(negedge clk);
        #1;
        check("held no restart busy", 32'(busy_v[1]), 32'd0);
        check("held single done", 32'(done_v[1]), 32'd0);
        run_op(1, 32'h0000_0100, 5'd1, 32'd8, "b2b ctz", 1'b0);

        for (int n = 0; n < 24; n++) begin
            v = $urandom;
            case ($urandom_range(0, 3))
                0:       v = v >> $urandom_range(0, 31);
                1:       v = v << $urandom_range(0, 31);
                2:       v = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'hFFFF_FFFF;
                default: ;
            endcase
            rs2 = 5'($urandom_range(0, 2));
            k   = $urandom_range(0, 2);
            run_op(k, v, rs2, ref_count(v, rs2), $sformatf("rand%0d k%0d v=%0h op=%0d", n, k, v, rs2), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
